seg_display_driver: RTL and testbench
=====================================

# seg_display_driver

Downstream display stage of the stopwatch: consumes the binary `minutes`/`seconds` values from the time counter and the `clk_fast`/`clk_blink` strobes from the clock divider. It drives a 4-digit multiplexed, common-anode seven-segment display in MM.SS form. The selected field blinks while adjust mode is active. All logic runs on the single system clock; the divider outputs are treated as sampled levels, not clocks.

## Interface
Parameters:
- none; digit count fixed at 4, field range fixed at 0–59.

Ports:
- `clk_in` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous, active-high reset.
- `minutes` in 6: binary minutes, 0–59.
- `seconds` in 6: binary seconds, 0–59.
- `adj` in 1: adjust mode active.
- `sel` in 1: field selector; 0 = minutes, 1 = seconds.
- `clk_fast` in 1: scan strobe level from the divider; each rising level advances one digit.
- `clk_blink` in 1: blink phase level; 1 = blank phase.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 4: digit anodes, active-low; `an[0]` is the rightmost digit.

## Operation
- Edge detect:
  - `fast_q` register holds the previous value of `clk_fast`.
  - `scan_tick = clk_fast & ~fast_q`.
- Digit index: 2-bit `idx`.
  - Increments on `scan_tick`.
  - Wraps 3→0.
- Snapshot:
  - On a `scan_tick` where `idx` is 3 (the wrap), register `minutes` and `seconds` into `min_s` and `sec_s`.
  - All four digits of one frame therefore come from the same value.
- Clamp: an input value above 59 is captured as 59.
- BCD conversion on snapshot values:
  - tens = value/10 (range 0–5).
  - ones = value mod 10.
  - Any implementation is acceptable (compare chain or double-dabble); the result must be registered before driving `seg`.
- Digit map:
  - idx0 → seconds ones.
  - idx1 → seconds tens.
  - idx2 → minutes ones.
  - idx3 → minutes tens.
- Anode: `an = ~(4'b0001 << idx)`. Exactly one anode is low at any time after reset.
- Decimal point: `dp = 0` only when `idx == 2` (separator after minutes), otherwise 1.
- Segment codes (active-low, `{g..a}`):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
- Blink:
  - Blanking condition: `adj = 1` and `clk_blink = 1` and the current digit belongs to the selected field.
    - `sel = 0`: idx 2, 3.
    - `sel = 1`: idx 0, 1.
  - When blanking, `seg = 1111111`.
  - `an` and `dp` are unaffected by blinking.
  - Blink inputs are sampled live, not from the snapshot.
- No leading-zero suppression; 00.00 displays all zeros.

## Timing
- Reset values (on the first edge with `rst = 1`):
  - `an = 1111`, `seg = 1111111`, `dp = 1`.
  - `idx = 0`, `fast_q = 0`.
  - `min_s = 0`, `sec_s = 0`.
- First scan after reset:
  - The first `scan_tick` after reset moves `idx` 0→1.
  - Outputs show idx 0 (seconds ones = 0) from the first non-reset edge.
- `rst` has priority over a simultaneous `scan_tick` and over the snapshot.
- Scan latency:
  - `clk_fast` sampled high at edge N, with `fast_q = 0`: `idx` updates at edge N.
  - `an`/`seg`/`dp` reflect the new digit at edge N+1.
- `clk_fast` held high for many cycles produces exactly one advance.
- Snapshot timing:
  - Snapshot and wrap occur at the same edge.
  - The digit-0 output at edge N+1 already uses the new snapshot.
- Input changes to `minutes`/`seconds` mid-frame have no visible effect until the next wrap.
- Blink changes (`adj`, `sel`, `clk_blink`) take effect 1 cycle after sampling.

## Test plan
- Reset: hold `rst` for 3 cycles → `an = 1111`, `seg = 1111111`, `dp = 1`; after release, `an = 1110`, `seg = 1000000`.
- Full frame:
  - Stimulus: `minutes = 12`, `seconds = 34`; drive 4 `clk_fast` pulses so the wrap snapshots the values.
  - Required response over the next 4 pulses: an1110/seg0011001 (4), an1101/seg0110000 (3), an1011/seg0100100/dp0 (2), an0111/seg1111001 (1).
- Strobe hold: `clk_fast` held high 20 cycles → `idx` advances once; output changes 1 cycle after the edge.
- Mid-frame change:
  - Stimulus: change `seconds` 34→59 while `idx = 1`.
  - Required response: tens digit still shows 3 until the next wrap; after the wrap, digit 0 shows 9 and digit 1 shows 5.
- Clamp: `minutes = 63` → minutes digits show 5 and 9.
- Blink:
  - `adj = 1`, `sel = 1`, `clk_blink = 1` → idx 0/1 show `seg = 1111111` with the anode still low; idx 2/3 are normal.
  - `clk_blink = 0` → all digits normal.
  - `rst` asserted mid-frame → `idx = 0` and blanked outputs next edge.

Source files
------------

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed MM.SS driver for a common-anode seven-segment display.
// Each frame shows a snapshot of the time taken at the digit wrap, so all four digits agree.
module seg_display_driver (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  input  logic       clk_fast,
  input  logic       clk_blink,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  logic       fast_q;
  logic [1:0] idx;
  logic [5:0] min_s;
  logic [5:0] sec_s;
  logic       scan_tick;
  logic [5:0] field;
  logic [7:0] bcd;
  logic [3:0] digit;
  logic       blank;

  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  // Repeated subtraction: the input never exceeds 59, so five passes are enough.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int k = 0; k < 5; k++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, 4'(r)};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign scan_tick = clk_fast & ~fast_q;

  always_comb begin
    field = idx[1] ? min_s : sec_s;
    bcd   = to_bcd(field);
    digit = idx[0] ? bcd[7:4] : bcd[3:0];
    blank = adj & clk_blink & (sel ? ~idx[1] : idx[1]);
  end

  // Outputs are built from the pre-update idx, so a new digit appears one edge after the advance.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      fast_q <= 1'b0;
      idx    <= 2'd0;
      min_s  <= 6'd0;
      sec_s  <= 6'd0;
      seg    <= 7'b1111111;
      dp     <= 1'b1;
      an     <= 4'b1111;
    end else begin
      fast_q <= clk_fast;
      if (scan_tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          min_s <= clamp59(minutes);
          sec_s <= clamp59(seconds);
        end
      end
      an  <= ~(4'b0001 << idx);
      dp  <= (idx != 2'd2);
      seg <= blank ? 7'b1111111 : seg_code(digit);
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: a cycle-level reference model built from
// plain div/mod arithmetic, directed scenarios, then randomized stimulus.
module tb_seg_display_driver;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       adj;
  logic       sel;
  logic       clk_fast;
  logic       clk_blink;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  always #5 clk_in = ~clk_in;

  seg_display_driver dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .minutes  (minutes),
    .seconds  (seconds),
    .adj      (adj),
    .sel      (sel),
    .clk_fast (clk_fast),
    .clk_blink(clk_blink),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [10];
  int         m_pos, m_sm, m_ss;
  logic       m_prev;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_an;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lim59(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  // Reference: the position shown on this edge is the one reached before this edge's advance.
  task automatic model_edge();
    int v, d;
    logic blank;
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      m_pos = 0; m_sm = 0; m_ss = 0; m_prev = 1'b0;
    end else begin
      v = (m_pos >= 2) ? m_sm : m_ss;
      d = (m_pos % 2 == 0) ? v % 10 : v / 10;
      blank = adj && clk_blink && (sel ? (m_pos < 2) : (m_pos >= 2));
      e_seg = blank ? 7'h7F : seg_tab[d];
      e_an  = 4'hF ^ (4'h1 << m_pos);
      e_dp  = (m_pos != 2);
      if (clk_fast && !m_prev) begin
        if (m_pos == 3) begin
          m_sm = lim59(int'(minutes));
          m_ss = lim59(int'(seconds));
        end
        m_pos = (m_pos + 1) % 4;
      end
      m_prev = clk_fast;
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic pulse(input int hi, input int lo);
    clk_fast = 1'b1;
    repeat (hi) cycle();
    clk_fast = 1'b0;
    repeat (lo) cycle();
  endtask

  logic [3:0] ff_an  [4];
  logic [6:0] ff_seg [4];
  logic       ff_dp  [4];

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    ff_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    ff_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    ff_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
    m_pos = 0; m_sm = 0; m_ss = 0; m_prev = 1'b0;

    rst = 1'b1; minutes = 6'd0; seconds = 6'd0; adj = 1'b0; sel = 1'b0;
    clk_fast = 1'b0; clk_blink = 1'b0;

    repeat (3) cycle();
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h0000007F);
    check("rst_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    cycle();
    check("post_rst_an", 32'(an), 32'b1110);
    check("post_rst_seg", 32'(seg), 32'b1000000);

    // Full frame 12:34
    minutes = 6'd12; seconds = 6'd34;
    repeat (4) pulse(1, 2);
    for (int i = 0; i < 4; i++) begin
      check("frame_an", 32'(an), 32'(ff_an[i]));
      check("frame_seg", 32'(seg), 32'(ff_seg[i]));
      check("frame_dp", 32'(dp), 32'(ff_dp[i]));
      pulse(1, 2);
    end

    // Long strobe: single advance, output moves one edge after the advance edge
    pulse(20, 2);
    check("hold_an", 32'(an), 32'b1101);

    // Mid-frame change at idx 1: tens still 3 until the wrap
    seconds = 6'd59;
    check("mid_tens_old", 32'(seg), 32'b0110000);
    repeat (2) pulse(1, 2);
    pulse(1, 2);
    check("mid_ones_new", 32'(seg), 32'b0010000);
    pulse(1, 2);
    check("mid_tens_new", 32'(seg), 32'b0010010);

    // Clamp minutes 63 -> 59
    minutes = 6'd63;
    repeat (3) pulse(1, 2);
    repeat (2) pulse(1, 2);
    check("clamp_ones", 32'(seg), 32'b0010000);
    pulse(1, 2);
    check("clamp_tens", 32'(seg), 32'b0010010);
    pulse(1, 2);

    // Blink seconds field, then blink off, then minutes field
    adj = 1'b1; sel = 1'b1; clk_blink = 1'b1;
    repeat (8) pulse(1, 2);
    clk_blink = 1'b0;
    repeat (4) pulse(1, 2);
    sel = 1'b0; clk_blink = 1'b1;
    repeat (4) pulse(1, 2);
    adj = 1'b0;

    // Reset mid-frame
    repeat (2) pulse(1, 2);
    rst = 1'b1;
    cycle();
    check("midrst_an", 32'(an), 32'h0000000F);
    rst = 1'b0;
    repeat (2) cycle();

    // Randomized
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) clk_fast = ~clk_fast;
      if ($urandom_range(0, 15) == 0) minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) seconds = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 31) == 0) adj = 1'($urandom);
      if ($urandom_range(0, 31) == 0) sel = 1'($urandom);
      if ($urandom_range(0, 7) == 0) clk_blink = 1'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
